tpu_result_drain: RTL and testbench

Read-side counterpart of the TPU result path. Once the array signals completion, this block walks the result SRAM row by row: it issues reads, absorbs the one-cycle SRAM read latency, and presents each 64×24-bit result row on a valid/ready stream to the host or bench. A 2-entry skid buffer with credit-based read issue gives full throughput with no row lost or duplicated under arbitrary backpressure.

---
 rtl/tpu_result_drain.sv | 203 ++++++++++++++++++++
 tb/tb_tpu_result_drain.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/tpu_result_drain.sv
// Result SRAM drain: walks MATRIX_SIZE result rows after TPU completion and streams them
// out over valid/ready through a 2-entry skid buffer with credit-gated read issue.
module tpu_result_drain #(
    parameter int ADDRESSSIZE     = 10,
    parameter int MATRIX_SIZE     = 64,
    parameter int PARTIAL_SUM_BW  = 24,
    parameter int WORDSIZE_Result = MATRIX_SIZE * PARTIAL_SUM_BW,
    parameter int IDXW            = $clog2(MATRIX_SIZE)
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       start,
    input  logic [ADDRESSSIZE-1:0]     base_addr,
    output logic                       rd_en,
    output logic [ADDRESSSIZE-1:0]     rd_addr,
    input  logic [WORDSIZE_Result-1:0] rd_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WORDSIZE_Result-1:0] out_data,
    output logic [IDXW-1:0]            out_index,
    output logic                       out_last,
    output logic                       busy,
    output logic                       done
);

    localparam int                 CNTW      = IDXW + 1;
    localparam logic [CNTW-1:0]    ISSUE_MAX = CNTW'(MATRIX_SIZE);
    localparam logic [CNTW-1:0]    ISSUE_END = CNTW'(MATRIX_SIZE - 1);
    localparam logic [IDXW-1:0]    IDX_LAST  = IDXW'(MATRIX_SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                     state_r;
    logic                       start_q_r;
    logic [ADDRESSSIZE-1:0]     base_r;
    logic [CNTW-1:0]            issue_cnt_r;
    logic                       busy_r;
    logic                       done_r;
    logic                       inflight_r;
    logic [IDXW-1:0]            inflight_idx_r;
    logic [1:0]                 occ_r;
    logic [WORDSIZE_Result-1:0] head_data_r;
    logic [IDXW-1:0]            head_idx_r;
    logic                       head_last_r;
    logic [WORDSIZE_Result-1:0] tail_data_r;
    logic [IDXW-1:0]            tail_idx_r;
    logic                       tail_last_r;

    logic                       trig_s;
    logic                       pop_s;
    logic                       push_s;
    logic                       rd_en_s;
    logic [2:0]                 credit_s;
    logic                       cap_last_s;

    assign out_valid = (occ_r != 2'd0);
    assign out_data  = head_data_r;
    assign out_index = head_idx_r;
    assign out_last  = head_last_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign rd_en     = rd_en_s;
    assign rd_addr   = base_r + ADDRESSSIZE'(issue_cnt_r);

    // Trigger detect, handshake, and credit-gated read issue for the current cycle.
    always_comb begin
        trig_s     = start && !start_q_r && (state_r == S_IDLE);
        pop_s      = (occ_r != 2'd0) && out_ready;
        push_s     = inflight_r;
        cap_last_s = (inflight_idx_r == IDX_LAST);
        credit_s   = {1'b0, occ_r} + {2'b00, inflight_r};
        if ((state_r == S_RUN) && (issue_cnt_r < ISSUE_MAX)) begin
            rd_en_s = (credit_s < (3'd2 + {2'b00, pop_s}));
        end else begin
            rd_en_s = 1'b0;
        end
    end

    // Start edge history; resets high so a level held across reset is not a new trigger.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            start_q_r <= 1'b1;
        end else begin
            start_q_r <= start;
        end
    end

    // Drain sequencer with registered busy/done.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= S_IDLE;
            base_r      <= {ADDRESSSIZE{1'b0}};
            issue_cnt_r <= {CNTW{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done_r <= 1'b0;
                    if (trig_s) begin
                        state_r     <= S_RUN;
                        base_r      <= base_addr;
                        issue_cnt_r <= {CNTW{1'b0}};
                        busy_r      <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (rd_en_s) begin
                        issue_cnt_r <= issue_cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
                        if (issue_cnt_r == ISSUE_END) begin
                            state_r <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (pop_s && head_last_r) begin
                        state_r <= S_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    // Tracks the read issued last cycle so its data lands with the right row index.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inflight_r     <= 1'b0;
            inflight_idx_r <= {IDXW{1'b0}};
        end else begin
            inflight_r <= rd_en_s;
            if (rd_en_s) begin
                inflight_idx_r <= issue_cnt_r[IDXW-1:0];
            end
        end
    end

    // Two-entry skid buffer; the head register drives the stream directly.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            occ_r       <= 2'd0;
            head_data_r <= {WORDSIZE_Result{1'b0}};
            head_idx_r  <= {IDXW{1'b0}};
            head_last_r <= 1'b0;
            tail_data_r <= {WORDSIZE_Result{1'b0}};
            tail_idx_r  <= {IDXW{1'b0}};
            tail_last_r <= 1'b0;
        end else begin
            occ_r <= occ_r + {1'b0, push_s} - {1'b0, pop_s};
            case (occ_r)
                2'd0: begin
                    if (push_s) begin
                        head_data_r <= rd_data;
                        head_idx_r  <= inflight_idx_r;
                        head_last_r <= cap_last_s;
                    end
                end
                2'd1: begin
                    if (push_s && pop_s) begin
                        head_data_r <= rd_data;
                        head_idx_r  <= inflight_idx_r;
                        head_last_r <= cap_last_s;
                    end else if (push_s) begin
                        tail_data_r <= rd_data;
                        tail_idx_r  <= inflight_idx_r;
                        tail_last_r <= cap_last_s;
                    end
                end
                2'd2: begin
                    if (pop_s) begin
                        head_data_r <= tail_data_r;
                        head_idx_r  <= tail_idx_r;
                        head_last_r <= tail_last_r;
                        if (push_s) begin
                            tail_data_r <= rd_data;
                            tail_idx_r  <= inflight_idx_r;
                            tail_last_r <= cap_last_s;
                        end
                    end
                end
                default: begin
                    occ_r <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tpu_result_drain.sv
// Randomized-data, directed-scenario bench for tpu_result_drain against a row-stream
// reference model (address arithmetic, outstanding-row count, ordered row list).
module tb_tpu_result_drain;

    localparam int W  = 1536;
    localparam int AW = 10;
    localparam int N  = 64;

    logic          clk;
    logic          rstn;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [5:0]    out_index;
    logic          out_last;
    logic          busy;
    logic          done;

    logic [W-1:0]  sram [0:1023];
    int            checks;
    int            errors;
    int            dcyc;

    tpu_result_drain dut (
        .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_last(out_last), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: one-cycle read latency, garbage on idle cycles.
    always @(posedge clk) begin
        if (rd_en) rd_data <= sram[rd_addr];
        else       rd_data <= {48{32'hDEAD_BEEF}};
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h_%h expected=%h_%h", tag,
                   obs[W-1:W-64], obs[63:0], exp[W-1:W-64], exp[63:0]);
        end
    endtask

    task automatic fill_sram();
        for (int a = 0; a < 1024; a++)
            for (int j = 0; j < W / 32; j++)
                sram[a][j*32 +: 32] = $urandom;
    endtask

    // mode: 0 ready=1, 1 random ready, 2 start toggling + base change, 3 ready=0 for 20 cycles,
    //       4 ready=1 until row 30 then stall and return mid-drain
    task automatic run_drain(input logic [AW-1:0] base, input int mode, output int done_cyc);
        int issued, popped, first_valid, stall;
        logic held, pop_now;
        logic [W-1:0] held_data;
        logic [5:0] held_idx;
        logic [AW-1:0] a;
        issued = 0; popped = 0; first_valid = -1; done_cyc = -1; held = 1'b0; stall = 0;
        @(negedge clk);
        base_addr = base;
        start = 1'b1;
        for (int k = 0; k < 600 && done_cyc < 0; k++) begin
            @(negedge clk);
            case (mode)
                1: out_ready = ($urandom_range(0, 1) == 1);
                2: begin
                    out_ready = 1'b1;
                    if (k == 5)  base_addr = base ^ 10'h155;
                    if (k == 10 || k == 40) start = 1'b0;
                    if (k == 12 || k == 41) start = 1'b1;
                end
                3: out_ready = (k >= 20);
                4: out_ready = (popped < 30);
                default: out_ready = 1'b1;
            endcase
            #1;
            if (held) begin
                chk("stall_valid", W'(out_valid), W'(1));
                chk("stall_data", out_data, held_data);
                chk("stall_index", W'(out_index), W'(held_idx));
            end
            if (k == 0) begin
                chk("first_rd_en", W'(rd_en), W'(1));
                chk("first_rd_addr", W'(rd_addr), W'(base));
            end
            if (mode == 3 && k == 19) begin
                chk("stall20_reads", W'(issued), W'(2));
                chk("stall20_valid", W'(out_valid), W'(1));
                chk("stall20_index", W'(out_index), W'(0));
            end
            if (mode == 3 && k == 20) chk("resume_rd_en", W'(rd_en), W'(1));
            pop_now = out_valid && out_ready;
            if (rd_en) begin
                a = base + AW'(issued);
                chk("credit", W'((issued - popped - int'(pop_now)) < 2), W'(1));
                chk("rd_addr", W'(rd_addr), W'(a));
                issued++;
            end
            if (out_valid && first_valid < 0) first_valid = k;
            if (pop_now) begin
                a = base + AW'(popped);
                chk("row_index", W'(out_index), W'(popped));
                chk("row_data", out_data, sram[a]);
                chk("row_last", W'(out_last), W'(popped == N - 1));
                popped++;
            end
            held = out_valid && !out_ready;
            held_data = out_data;
            held_idx = out_index;
            if (done) begin
                done_cyc = k;
                chk("done_rows", W'(popped), W'(N));
                chk("done_busy", W'(busy), W'(0));
            end else begin
                chk("busy_run", W'(busy), W'(1));
            end
            if (!out_ready) stall++;
            if (mode == 4 && popped == 30 && stall == 3) break;
        end
        if (mode != 4) begin
            chk("done_seen", W'(done_cyc >= 0), W'(1));
            chk("reads_total", W'(issued), W'(N));
            chk("rows_total", W'(popped), W'(N));
            if (mode == 0) begin
                chk("done_cycle", W'(done_cyc), W'(66));
                chk("first_valid_cycle", W'(first_valid), W'(2));
            end
            @(negedge clk); #1;
            chk("done_pulse", W'(done), W'(0));
            chk("idle_busy", W'(busy), W'(0));
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        rstn = 1'b0; start = 1'b0; out_ready = 1'b0; base_addr = '0; rd_data = '0;
        fill_sram();
        #1;
        chk("rst_rd_en", W'(rd_en), W'(0));
        chk("rst_rd_addr", W'(rd_addr), W'(0));
        chk("rst_valid", W'(out_valid), W'(0));
        chk("rst_data", out_data, W'(0));
        chk("rst_index", W'(out_index), W'(0));
        chk("rst_last", W'(out_last), W'(0));
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done", W'(done), W'(0));
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        run_drain(10'd0, 0, dcyc);
        start = 1'b0; @(negedge clk);
        fill_sram();
        run_drain(10'd0, 1, dcyc);
        start = 1'b0; @(negedge clk);
        run_drain(10'd1000, 0, dcyc);
        start = 1'b0; @(negedge clk);

        run_drain(10'd37, 2, dcyc);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            chk("no_retrigger_busy", W'(busy), W'(0));
            chk("no_retrigger_rd", W'(rd_en), W'(0));
        end
        start = 1'b0; @(negedge clk);
        run_drain(10'd200, 1, dcyc);
        start = 1'b0; @(negedge clk);

        run_drain(10'd5, 4, dcyc);
        rstn = 1'b0;
        #1;
        chk("midrst_rd_en", W'(rd_en), W'(0));
        chk("midrst_rd_addr", W'(rd_addr), W'(0));
        chk("midrst_valid", W'(out_valid), W'(0));
        chk("midrst_data", out_data, W'(0));
        chk("midrst_index", W'(out_index), W'(0));
        chk("midrst_last", W'(out_last), W'(0));
        chk("midrst_busy", W'(busy), W'(0));
        chk("midrst_done", W'(done), W'(0));
        repeat (3) begin
            @(negedge clk); #1;
            chk("inrst_rd_en", W'(rd_en), W'(0));
        end
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("postrst_idle", W'(busy | rd_en | out_valid), W'(0));
        end
        start = 1'b0; @(negedge clk);
        run_drain(10'd0, 0, dcyc);
        start = 1'b0; @(negedge clk);

        run_drain(10'd64, 3, dcyc);
        start = 1'b0; @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
